// File: rtl/line_scheduler.sv
// line_scheduler: walks a circular FIFO of board lines (rows then columns).
// For each line it sends a header word, then every stored option pattern, to
// an external solver. After the solver's verdict the line is dropped or
// re-queued. A watchdog on the number of line evaluations flags a solve that
// cannot converge.
module line_scheduler #(
  parameter int SIZE      = 3,
  parameter int MAX_OPTS  = 8,
  parameter int MAX_EVALS = 64,
  localparam int LINES    = 2 * SIZE,
  localparam int LW       = $clog2(LINES),
  localparam int OW       = $clog2(MAX_OPTS),
  localparam int EW       = $clog2(MAX_EVALS + 1),
  localparam int CW       = $clog2(LINES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [LW-1:0]      cnt_addr,
  input  logic [OW:0]        cnt_data,
  output logic [LW+OW-1:0]   opt_addr,
  input  logic [SIZE-1:0]    opt_data,
  output logic               started,
  output logic [SIZE-1:0]    option,
  output logic               valid_op,
  input  logic               put_back_to_FIFO,
  input  logic               solved,
  output logic               busy,
  output logic               done,
  output logic               stuck,
  output logic [EW-1:0]      evals
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_HDR,
    S_OPT,
    S_JUDGE,
    S_DONE,
    S_STUCK
  } state_t;

  state_t state_q, state_d;

  // Circular line FIFO; contents need no reset because occupancy guards them.
  logic [LW-1:0] fifo_q [LINES];
  logic [LW-1:0] head_q, tail_q;
  logic [CW-1:0] occ_q;

  logic [LW-1:0] cur_line_q;
  logic [OW:0]   opt_cnt_q;
  logic [OW-1:0] opt_idx_q;
  logic [OW-1:0] opt_idx_nxt;
  logic          first_hdr_q;
  logic [EW-1:0] evals_q;

  // Control strobes from the FSM into the datapath.
  logic do_init;
  logic do_pop;
  logic do_push;
  logic do_latch_cnt;
  logic adv_idx;
  logic inc_evals;
  logic clear_evals;

  // A count above the storage depth can never be walked, so it is clamped.
  logic [OW:0] cnt_eff;
  assign cnt_eff = (cnt_data > (OW+1)'(MAX_OPTS)) ? (OW+1)'(MAX_OPTS) : cnt_data;

  assign opt_idx_nxt = opt_idx_q + OW'(1);
  assign evals       = evals_q;

  function automatic logic [LW-1:0] ptr_inc(input logic [LW-1:0] p);
    return (p == LW'(LINES - 1)) ? '0 : p + LW'(1);
  endfunction

  // State register; reset drops any solve in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, output words and datapath strobes per state.
  always_comb begin
    state_d      = state_q;
    do_init      = 1'b0;
    do_pop       = 1'b0;
    do_push      = 1'b0;
    do_latch_cnt = 1'b0;
    adv_idx      = 1'b0;
    inc_evals    = 1'b0;
    clear_evals  = 1'b0;
    cnt_addr     = '0;
    opt_addr     = '0;
    started      = 1'b0;
    option       = '0;
    valid_op     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    stuck        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear_evals = 1'b1;
          state_d     = S_INIT;
        end
      end

      S_INIT: begin
        busy    = 1'b1;
        do_init = 1'b1;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        busy = 1'b1;
        if (occ_q == '0) begin
          state_d = S_DONE;
        end else if (evals_q == EW'(MAX_EVALS)) begin
          state_d = S_STUCK;
        end else begin
          do_pop   = 1'b1;
          cnt_addr = fifo_q[head_q];
          state_d  = S_HDR;
        end
      end

      S_HDR: begin
        busy         = 1'b1;
        valid_op     = 1'b1;
        option       = SIZE'(cur_line_q);
        started      = first_hdr_q;
        opt_addr     = {cur_line_q, OW'(0)};
        do_latch_cnt = 1'b1;
        if (cnt_eff == '0) begin
          inc_evals = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_OPT;
        end
      end

      S_OPT: begin
        busy     = 1'b1;
        valid_op = 1'b1;
        option   = opt_data;
        opt_addr = {cur_line_q, opt_idx_nxt};
        adv_idx  = 1'b1;
        if ({1'b0, opt_idx_q} == opt_cnt_q - (OW+1)'(1)) begin
          state_d = S_JUDGE;
        end
      end

      S_JUDGE: begin
        busy      = 1'b1;
        inc_evals = 1'b1;
        if (solved) begin
          state_d = S_DONE;
        end else begin
          do_push = put_back_to_FIFO;
          state_d = S_FETCH;
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (start) begin
          clear_evals = 1'b1;
          state_d     = S_INIT;
        end
      end

      S_STUCK: begin
        stuck = 1'b1;
        if (start) begin
          clear_evals = 1'b1;
          state_d     = S_INIT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO storage: filled with 0..LINES-1 at the start of a solve, re-queued lines at the tail.
  always_ff @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < LINES; i++) begin
        fifo_q[i] <= LW'(i);
      end
    end else if (do_push) begin
      fifo_q[tail_q] <= cur_line_q;
    end
  end

  // Pointers, occupancy, current line bookkeeping and the evaluation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      cur_line_q  <= '0;
      opt_cnt_q   <= '0;
      opt_idx_q   <= '0;
      first_hdr_q <= 1'b0;
      evals_q     <= '0;
    end else begin
      if (do_init) begin
        head_q      <= '0;
        tail_q      <= '0;
        occ_q       <= CW'(LINES);
        first_hdr_q <= 1'b1;
      end
      if (do_pop) begin
        cur_line_q <= fifo_q[head_q];
        head_q     <= ptr_inc(head_q);
        occ_q      <= occ_q - CW'(1);
      end
      if (do_push) begin
        tail_q <= ptr_inc(tail_q);
        occ_q  <= occ_q + CW'(1);
      end
      if (do_latch_cnt) begin
        opt_cnt_q   <= cnt_eff;
        opt_idx_q   <= '0;
        first_hdr_q <= 1'b0;
      end
      if (adv_idx) begin
        opt_idx_q <= opt_idx_nxt;
      end
      if (clear_evals) begin
        evals_q <= '0;
      end else if (inc_evals) begin
        evals_q <= evals_q + EW'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_scheduler.sv
// tb_line_scheduler: randomized and directed solves against a queue-based
// reference model. Expected words go into a scoreboard queue; a monitor pops
// them whenever valid_op is high. A small solver model answers verdicts.
module tb_line_scheduler;

  localparam int SIZE      = 3;
  localparam int MAX_OPTS  = 8;
  localparam int MAX_EVALS = 10;
  localparam int LINES     = 2 * SIZE;
  localparam int LW        = $clog2(LINES);
  localparam int OW        = $clog2(MAX_OPTS);
  localparam int EW        = $clog2(MAX_EVALS + 1);
  localparam int NDEC      = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LW-1:0]     cnt_addr;
  logic [OW:0]       cnt_data;
  logic [LW+OW-1:0]  opt_addr;
  logic [SIZE-1:0]   opt_data;
  logic              started;
  logic [SIZE-1:0]   option;
  logic              valid_op;
  logic              put_back_to_FIFO;
  logic              solved;
  logic              busy;
  logic              done;
  logic              stuck;
  logic [EW-1:0]     evals;

  line_scheduler #(
    .SIZE(SIZE),
    .MAX_OPTS(MAX_OPTS),
    .MAX_EVALS(MAX_EVALS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cnt_addr(cnt_addr),
    .cnt_data(cnt_data),
    .opt_addr(opt_addr),
    .opt_data(opt_data),
    .started(started),
    .option(option),
    .valid_op(valid_op),
    .put_back_to_FIFO(put_back_to_FIFO),
    .solved(solved),
    .busy(busy),
    .done(done),
    .stuck(stuck),
    .evals(evals)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            started;
    logic [SIZE-1:0] word;
    int              gap;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic [OW:0]     cnt_mem [LINES];
  logic [SIZE-1:0] opt_mem [LINES][MAX_OPTS];
  bit              dec_solved [NDEC];
  bit              dec_pb [NDEC];
  int              judge_k;

  // Option-count and option memories with one cycle of read latency.
  always @(posedge clk) begin
    cnt_data <= (int'(cnt_addr) < LINES) ? cnt_mem[cnt_addr] : '0;
    if (int'(opt_addr[LW+OW-1:OW]) < LINES)
      opt_data <= opt_mem[opt_addr[LW+OW-1:OW]][opt_addr[OW-1:0]];
    else
      opt_data <= '0;
  end

  // Monitor: pops an expected word for each valid cycle and checks spacing; idle cycles must be zero.
  int   cycle_no   = 0;
  int   last_valid = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    cycle_no++;
    if (valid_op === 1'b1) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_word: got started=%0b word=%b, none expected", started, option);
      end else begin
        mon_e = sb.pop_front();
        if (started !== mon_e.started || option !== mon_e.word) begin
          mismatched++;
          $display("[TB] FAIL word: got started=%0b word=%b, expected started=%0b word=%b",
                   started, option, mon_e.started, mon_e.word);
        end
        if (mon_e.gap > 0) begin
          compared++;
          if (cycle_no - last_valid != mon_e.gap) begin
            mismatched++;
            $display("[TB] FAIL word_spacing: got %0d cycles, expected %0d",
                     cycle_no - last_valid, mon_e.gap);
          end
        end
      end
      last_valid = cycle_no;
    end else begin
      compared++;
      if (option !== '0 || started !== 1'b0 || valid_op !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL idle_word: got valid=%b started=%b word=%b, expected all zero",
                 valid_op, started, option);
      end
    end
  end

  // Solver model: random noise on verdict inputs, real verdict held across the cycle after the last option.
  int rem  = 0;
  bit hold = 0;
  always @(negedge clk) begin
    if (rst) begin
      rem              = 0;
      hold             = 0;
      solved           = 1'b0;
      put_back_to_FIFO = 1'b0;
    end else if (hold) begin
      hold = 0;
    end else begin
      solved           = 1'($urandom_range(0, 1));
      put_back_to_FIFO = 1'($urandom_range(0, 1));
      if (valid_op === 1'b1) begin
        if (rem == 0) begin
          rem = (int'(option) < LINES) ? int'(cnt_mem[option]) : 0;
        end else begin
          rem--;
          if (rem == 0) begin
            solved           = dec_solved[judge_k % NDEC];
            put_back_to_FIFO = dec_pb[judge_k % NDEC];
            judge_k++;
            hold = 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: a plain queue of line numbers walked by the scheduling rules.
  task automatic build_model(output bit e_done, output bit e_stuck, output int e_evals);
    int   q[$];
    int   ev = 0;
    int   k = 0;
    int   prev_gap = 0;
    bit   first = 1;
    bit   fin = 0;
    int   ln;
    int   n;
    exp_t e;
    e_done  = 0;
    e_stuck = 0;
    for (int i = 0; i < LINES; i++) q.push_back(i);
    while (!fin) begin
      if (q.size() == 0) begin
        e_done = 1;
        fin = 1;
      end else if (ev == MAX_EVALS) begin
        e_stuck = 1;
        fin = 1;
      end else begin
        ln = q.pop_front();
        e.started = first;
        e.word    = SIZE'(ln);
        e.gap     = first ? 0 : prev_gap;
        sb.push_back(e);
        first = 0;
        n = int'(cnt_mem[ln]);
        ev++;
        if (n == 0) begin
          prev_gap = 2;
        end else begin
          for (int j = 0; j < n; j++) begin
            e.started = 1'b0;
            e.word    = opt_mem[ln][j];
            e.gap     = 1;
            sb.push_back(e);
          end
          prev_gap = 3;
          if (dec_solved[k]) begin
            e_done = 1;
            fin = 1;
          end else if (dec_pb[k]) begin
            q.push_back(ln);
          end
          k++;
        end
      end
    end
    e_evals = ev;
  endtask

  task automatic checkOutput(input bit timed_out, input bit e_done, input bit e_stuck, input int e_evals);
    check("finish_in_time", 32'(timed_out), 32'd0);
    check("done", 32'(done), 32'(e_done));
    check("stuck", 32'(stuck), 32'(e_stuck));
    check("evals", 32'(evals), 32'(e_evals));
    check("busy_after", 32'(busy), 32'd0);
    check("words_left", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("done_held", 32'(done), 32'(e_done));
    check("stuck_held", 32'(stuck), 32'(e_stuck));
  endtask

  task automatic applyStimulus(input bit extra_start);
    bit e_done, e_stuck;
    int e_evals;
    int n = 0;
    build_model(e_done, e_stuck, e_evals);
    judge_k = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (extra_start) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    while (!(done === 1'b1 || stuck === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(n >= 2000, e_done, e_stuck, e_evals);
  endtask

  task automatic fill_random(input int max_cnt, input bit allow_zero);
    for (int l = 0; l < LINES; l++) begin
      cnt_mem[l] = (OW+1)'($urandom_range(allow_zero ? 0 : 1, max_cnt));
      for (int j = 0; j < MAX_OPTS; j++) opt_mem[l][j] = SIZE'($urandom_range(0, 7));
    end
  endtask

  task automatic set_decisions(input int solved_at, input int pb_mode);
    for (int k = 0; k < NDEC; k++) begin
      dec_solved[k] = (k == solved_at);
      case (pb_mode)
        0: dec_pb[k] = 0;
        1: dec_pb[k] = 1;
        2: dec_pb[k] = (k == 1);
        default: dec_pb[k] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  initial begin
    int n;
    rst              = 1'b1;
    start            = 1'b0;
    solved           = 1'b0;
    put_back_to_FIFO = 1'b0;
    judge_k          = 0;
    fill_random(3, 0);
    set_decisions(-1, 0);
    repeat (2) @(negedge clk);
    check("rst_started", 32'(started), 32'd0);
    check("rst_option", 32'(option), 32'd0);
    check("rst_valid_op", 32'(valid_op), 32'd0);
    check("rst_cnt_addr", 32'(cnt_addr), 32'd0);
    check("rst_opt_addr", 32'(opt_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    check("rst_evals", 32'(evals), 32'd0);
    rst = 1'b0;

    $display("[TB] directed: counts 2,3,1,1,2,3, solved at sixth verdict");
    fill_random(3, 0);
    cnt_mem[0] = 2; cnt_mem[1] = 3; cnt_mem[2] = 1;
    cnt_mem[3] = 1; cnt_mem[4] = 2; cnt_mem[5] = 3;
    opt_mem[0][0] = 3'b110;
    opt_mem[0][1] = 3'b011;
    set_decisions(5, 0);
    applyStimulus(0);

    $display("[TB] directed: line 1 put back once");
    fill_random(3, 0);
    set_decisions(-1, 2);
    applyStimulus(0);

    $display("[TB] directed: always put back, watchdog");
    fill_random(3, 0);
    set_decisions(-1, 1);
    applyStimulus(0);

    $display("[TB] directed: empty line 4 and start while busy");
    fill_random(3, 0);
    cnt_mem[4] = 0;
    set_decisions(-1, 0);
    applyStimulus(1);

    $display("[TB] directed: reset during options of line 2");
    for (int l = 0; l < LINES; l++) begin
      cnt_mem[l] = 2;
      for (int j = 0; j < MAX_OPTS; j++) opt_mem[l][j] = 3'b111;
    end
    set_decisions(-1, 0);
    begin
      bit d0, s0;
      int ev0;
      build_model(d0, s0, ev0);
    end
    judge_k = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(valid_op === 1'b1 && option === 3'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_line2", 32'(n >= 200), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid_op", 32'(valid_op), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_evals", 32'(evals), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0);

    $display("[TB] randomized solves");
    for (int t = 0; t < 20; t++) begin
      fill_random(5, 1);
      for (int k = 0; k < NDEC; k++) begin
        dec_solved[k] = ($urandom_range(0, 7) == 0);
        dec_pb[k]     = 1'($urandom_range(0, 1));
      end
      applyStimulus(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
